alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
- REQ-001 SHALL have parameter W, default 4: operand, result and opcode width.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-004 SHALL have port in_valid, input, 1: upstream ALU/flag_calculator result valid.
- REQ-005 SHALL have port in_ready, output, 1: stage can accept this cycle.
- REQ-006 SHALL have port in_opcode, input, W: opcode of the result.
- REQ-007 SHALL have port in_result, input, W: op_result from the ALU.
- REQ-008 SHALL have port in_flags, input, 4: {negative, zero, cout, overflow} from flag_calculator.
- REQ-009 SHALL have port out_valid, output, 1: registered result available.
- REQ-010 SHALL have port out_ready, input, 1: downstream consumes this cycle.
- REQ-011 SHALL have port out_opcode, output, W: registered opcode.
- REQ-012 SHALL have port out_result, output, W: registered result.
- REQ-013 SHALL have port out_flags, output, 4: registered masked flags, same bit order as in_flags.
- REQ-014 SHALL have port clear_sticky, input, 1: clear accumulated flags.
- REQ-015 SHALL have port sticky_flags, output, 4: OR of all accepted masked flags since last clear.

Function
- REQ-016 SHALL accept a transfer when in_valid && in_ready, and present it when out_valid && out_ready.
- REQ-017 SHALL be a two-entry skid buffer (main + skid), states EMPTY, ONE, FULL.
- REQ-018 SHALL transition: EMPTY+accept->ONE; ONE+accept-only->FULL; ONE+consume-only->EMPTY; ONE+accept+consume->ONE; FULL+consume->ONE (skid moves to main); others hold.
- REQ-019 SHALL drive in_ready = (state != FULL) from a register, with no combinational path from out_ready.
- REQ-020 SHALL drive out_valid = (state != EMPTY); out_* come from the main entry only.
- REQ-021 SHALL have latency 1: data accepted at edge N is visible on out_* after edge N when the stage was EMPTY.
- REQ-022 SHALL preserve order; no drop or duplicate under any in_valid/out_ready pattern.
- REQ-023 SHALL hold out_* stable while out_valid && !out_ready.
- REQ-024 SHALL mask flags on capture: cout and overflow forced 0 unless opcode is ADD_OP or SUB_OP; negative and zero pass unchanged.
- REQ-025 SHALL update sticky_flags on accept: sticky <= sticky | masked flags.
- REQ-026 SHALL give clear priority: if clear_sticky and accept occur in the same cycle, sticky <= masked flags of that transfer.
- REQ-027 SHALL ignore in_* when !in_ready; data present with in_valid low has no effect.

Reset
- REQ-028 SHALL, on rst_n low, immediately force state EMPTY, out_valid 0, in_ready 0, out_opcode/out_result/out_flags 0, sticky_flags 0.
- REQ-029 SHALL raise in_ready on the first clk edge after rst_n deasserts.
- REQ-030 SHALL discard any buffered entries on reset mid-transfer.

Configuration
- REQ-031 SHALL, with ALU_STICKY_FLAGS_EN defined, implement sticky_flags per REQ-025/026.
- REQ-032 SHALL, without ALU_STICKY_FLAGS_EN, tie sticky_flags to 0, ignore clear_sticky and keep no sticky register; all ports remain.

Structure
- REQ-033 SHALL take ADD_OP/SUB_OP from package alu_ops, which also gains the flag-bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and a packed entry typedef {opcode, result, flags}.
- REQ-034 SHALL place storage in one sub-module, alu_skid_buffer, parameterised on entry width; masking and sticky logic stay in alu_result_stage.

Verification
- REQ-035 SHALL check: reset, then ADD_OP result 4'h0 flags 4'b0110, out_ready=1 -> next cycle out_valid=1, out_flags=4'b0110, in_ready=1.
- REQ-036 SHALL check: out_ready=0, three back-to-back valid inputs -> first two accepted, in_ready=0 after the second, third held; out_ready=1 -> outputs appear in order with no loss.
- REQ-037 SHALL check: a non-ADD/SUB opcode with in_flags 4'b1011 -> out_flags=4'b1000.
- REQ-038 SHALL check: accept V=1, then accept with flags 0 -> sticky_flags=4'b0001; clear_sticky plus an accept with Z=1 in the same cycle -> sticky=4'b0100.
- REQ-039 SHALL check: rst_n low while FULL -> out_valid=0 and sticky=0 immediately; after release the first output is new data only.
- REQ-040 SHALL check: a random valid/ready soak of 10k cycles -> scoreboard matches in order and out_* are stable under stall.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Shared ALU opcodes, flag bit positions, skid-buffer states and the result-stage
// entry layout (entry typedef sized for the default 4-bit datapath).
package alu_ops;

  localparam int unsigned ADD_OP = 0;
  localparam int unsigned SUB_OP = 1;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned ALU_W = 4;

  typedef struct packed {
    logic [ALU_W-1:0] opcode;
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
  } alu_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_e;

  // Carry and overflow only mean something for add/subtract results.
  function automatic logic [3:0] mask_flags(input logic is_arith, input logic [3:0] flags);
    logic [3:0] m;
    m = flags;
    if (!is_arith) begin
      m[FLAG_C] = 1'b0;
      m[FLAG_V] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry (main + skid) ready/valid buffer; in_ready is registered so the
// upstream side has no combinational path from out_ready.
module alu_skid_buffer
  import alu_ops::*;
#(
  parameter int unsigned EW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [EW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [EW-1:0] out_data_o
);

  skid_state_e   state_q, state_d;
  logic          in_ready_q;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          accept;
  logic          consume;

  assign accept  = in_valid_i && in_ready_q;
  assign consume = (state_q != EMPTY) && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready_q stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag masking on capture, skid-buffered handshake,
// optional sticky flag accumulator enabled by ALU_STICKY_FLAGS_EN.
module alu_result_stage
  import alu_ops::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_opcode,
  input  logic [W-1:0] in_result,
  input  logic [3:0]   in_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_opcode,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags,
  input  logic         clear_sticky,
  output logic [3:0]   sticky_flags
);

  typedef struct packed {
    logic [W-1:0] opcode;
    logic [W-1:0] result;
    logic [3:0]   flags;
  } entry_t;

  logic       is_arith;
  logic [3:0] masked_flags;
  entry_t     in_entry;
  entry_t     out_entry;

  assign is_arith     = (in_opcode == W'(ADD_OP)) || (in_opcode == W'(SUB_OP));
  assign masked_flags = mask_flags(is_arith, in_flags);
  assign in_entry     = '{opcode: in_opcode, result: in_result, flags: masked_flags};

  alu_skid_buffer #(
    .EW($bits(entry_t))
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_entry),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_entry)
  );

  assign out_opcode = out_entry.opcode;
  assign out_result = out_entry.result;
  assign out_flags  = out_entry.flags;

`ifdef ALU_STICKY_FLAGS_EN
  logic       accept;
  logic [3:0] sticky_q, sticky_d;

  assign accept = in_valid && in_ready;

  // Clear wins over history but not over the flags arriving in the same cycle.
  always_comb begin
    sticky_d = clear_sticky ? '0 : sticky_q;
    if (accept) sticky_d = sticky_d | masked_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_flags        = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a random handshake soak.
module tb_alu_result_stage;
  import alu_ops::*;

  localparam int unsigned W = 4;
`ifdef ALU_STICKY_FLAGS_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_opcode = '0;
  logic [W-1:0] in_result = '0;
  logic [3:0]   in_flags = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_opcode;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         clear_sticky = 1'b0;
  logic [3:0]   sticky_flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .clear_sticky(clear_sticky),
    .sticky_flags(sticky_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  alu_entry_t mq[$];
  logic [3:0] m_sticky = '0;
  bit         m_armed = 1'b0;
  int         epoch = 0;

  function automatic logic [3:0] ref_mask(input logic [3:0] op, input logic [3:0] f);
    if (op == 4'(ADD_OP) || op == 4'(SUB_OP)) return f;
    return {f[3:2], 2'b00};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky = '0;
      m_armed  = 1'b0;
      epoch++;
    end else begin
      bit acc;
      bit con;
      acc = in_valid && m_armed && (mq.size() < 2);
      con = out_ready && (mq.size() > 0);
      if (STICKY_EN) begin
        if (clear_sticky) m_sticky = '0;
        if (acc) m_sticky = m_sticky | ref_mask(in_opcode, in_flags);
      end
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back('{opcode: in_opcode, result: in_result,
                              flags: ref_mask(in_opcode, in_flags)});
      m_armed = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  alu_entry_t prev_out;
  bit         prev_stall = 1'b0;
  int         prev_epoch = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, m_armed && (mq.size() < 2));
      check("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("out_opcode", out_opcode, mq[0].opcode);
        check("out_result", out_result, mq[0].result);
        check("out_flags", out_flags, mq[0].flags);
      end
      check("sticky", sticky_flags, m_sticky);
      if (prev_stall && prev_epoch == epoch)
        check("stall_stable", {out_opcode, out_result, out_flags}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = '{opcode: out_opcode, result: out_result, flags: out_flags};
      prev_epoch = epoch;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] res,
                       input logic [3:0] fl);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_flags  = fl;
  endtask

  initial begin
    // reset state
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", {out_opcode, out_result, out_flags}, 12'h000);
    check("rst_sticky", sticky_flags, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 1'b0);
    tick();
    check("rel_in_ready_high", in_ready, 1'b1);

    // first transfer, latency 1
    out_ready = 1'b1;
    drive(1'b1, 4'(ADD_OP), 4'h0, 4'b0110);
    tick();
    check("lat1_valid", out_valid, 1'b1);
    check("lat1_flags", out_flags, 4'b0110);
    check("lat1_in_ready", in_ready, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    check("lat1_drained", out_valid, 1'b0);

    // back-to-back under stall
    out_ready = 1'b0;
    drive(1'b1, 4'(ADD_OP), 4'h1, 4'b0000);
    tick();
    check("b2b_first", out_result, 4'h1);
    check("b2b_ready1", in_ready, 1'b1);
    in_result = 4'h2;
    tick();
    check("b2b_ready_full", in_ready, 1'b0);
    check("b2b_hold1", out_result, 4'h1);
    in_result = 4'h3;
    tick();
    check("b2b_third_held", in_ready, 1'b0);
    check("b2b_hold2", out_result, 4'h1);
    out_ready = 1'b1;
    tick();
    check("b2b_second_out", out_result, 4'h2);
    tick();
    check("b2b_third_out", out_result, 4'h3);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    check("b2b_empty", out_valid, 1'b0);

    // flag masking for a non-arithmetic opcode
    drive(1'b1, 4'h5, 4'h7, 4'b1011);
    tick();
    check("mask_flags", out_flags, 4'b1000);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();

    // sticky accumulation and clear priority
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check("sticky_cleared", sticky_flags, 4'b0000);
    drive(1'b1, 4'(ADD_OP), 4'h4, 4'b0001);
    tick();
    check("sticky_v", sticky_flags, STICKY_EN ? 4'b0001 : 4'b0000);
    in_flags = 4'b0000;
    tick();
    check("sticky_keep", sticky_flags, STICKY_EN ? 4'b0001 : 4'b0000);
    clear_sticky = 1'b1;
    in_flags     = 4'b0100;
    tick();
    check("sticky_clr_acc", sticky_flags, STICKY_EN ? 4'b0100 : 4'b0000);
    clear_sticky = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();

    // reset while full
    out_ready = 1'b0;
    drive(1'b1, 4'(ADD_OP), 4'hA, 4'b0001);
    tick();
    in_result = 4'hB;
    tick();
    check("full_before_rst", in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_sticky", sticky_flags, 4'b0000);
    check("midrst_result", out_result, 4'h0);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    drive(1'b1, 4'(SUB_OP), 4'h9, 4'b0000);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    check("post_rst_no_old", out_valid, 1'b0);
    tick();
    check("post_rst_new_valid", out_valid, 1'b1);
    check("post_rst_new_data", out_result, 4'h9);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    check("post_rst_no_dup", out_valid, 1'b0);

    // random soak
    for (int i = 0; i < 10000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 1) != 0);
      in_opcode    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      in_result    = 4'($urandom);
      in_flags     = 4'($urandom);
      clear_sticky = ($urandom_range(0, 15) == 0);
      tick();
    end

    drive(1'b0, 4'h0, 4'h0, 4'h0);
    clear_sticky = 1'b0;
    out_ready    = 1'b1;
    repeat (4) tick();
    check("drain_empty", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
